// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input stage, the switch allocator and the crossbar.
// The slave side is the allocator; the master side is whatever drives requests and handshakes.
interface switch_allocator_if #(
  parameter int INPUTS        = 4,
  parameter int OUTPUTS       = 4,
  parameter int REQUEST_WIDTH = 32
);
  logic [INPUTS-1:0][REQUEST_WIDTH-1:0]  request;
  logic [INPUTS-1:0]                     request_valid;
  logic [INPUTS-1:0]                     valid_in;
  logic [INPUTS-1:0]                     ready_in;
  logic [INPUTS-1:0]                     tail_in;
  logic [OUTPUTS-1:0][REQUEST_WIDTH-1:0] routeSelect;
  logic [OUTPUTS-1:0]                    outputBusy;
  logic [INPUTS-1:0]                     PortReserved;
  logic                                  err_bad_dest;

  modport master (
    output request, request_valid, valid_in, ready_in, tail_in,
    input  routeSelect, outputBusy, PortReserved, err_bad_dest
  );

  modport slave (
    input  request, request_valid, valid_in, ready_in, tail_in,
    output routeSelect, outputBusy, PortReserved, err_bad_dest
  );
endinterface

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator: grants a whole-packet path from an input to an
// output on a head-flit request and releases it on the tail handshake of the owning input.
module switch_allocator #(
  parameter int INPUTS        = 4,
  parameter int OUTPUTS       = 4,
  parameter int REQUEST_WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  switch_allocator_if.slave bus
);

  localparam int IDX_W  = (INPUTS  > 1) ? $clog2(INPUTS)  : 1;
  localparam int DEST_W = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e                                r_state [OUTPUTS];
  state_e                                w_state_nxt [OUTPUTS];
  logic [OUTPUTS-1:0][REQUEST_WIDTH-1:0] r_route_sel;
  logic [OUTPUTS-1:0][IDX_W-1:0]         r_rr_ptr;
  logic [INPUTS-1:0]                     r_reserved;
  logic                                  r_err;

  logic [OUTPUTS-1:0][INPUTS-1:0]        w_elig;
  logic                                  w_bad;
  logic [OUTPUTS-1:0]                    w_grant;
  logic [OUTPUTS-1:0][IDX_W-1:0]         w_winner;
  logic [IDX_W-1:0]                      w_cand;
  logic [OUTPUTS-1:0]                    w_take;
  logic [OUTPUTS-1:0]                    w_release;
  logic [INPUTS-1:0]                     w_reserved_nxt;

  // Sort unreserved head requests into per-output eligibility; the full-width compare
  // makes any nonzero upper bit a bad destination.
  always_comb begin
    w_elig = '0;
    w_bad  = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      if (bus.request_valid[i] && !r_reserved[i]) begin
        if (bus.request[i] < REQUEST_WIDTH'(OUTPUTS)) begin
          w_elig[bus.request[i][DEST_W-1:0]][i] = 1'b1;
        end else begin
          w_bad = 1'b1;
        end
      end else begin
        w_bad = w_bad;
      end
    end
  end

  // Round-robin pick per output, scanning upward from the pointer with wraparound.
  always_comb begin
    w_grant  = '0;
    w_winner = '0;
    w_cand   = '0;
    for (int o = 0; o < OUTPUTS; o++) begin
      for (int k = 0; k < INPUTS; k++) begin
        w_cand = IDX_W'((int'(r_rr_ptr[o]) + k) % INPUTS);
        if (!w_grant[o] && w_elig[o][w_cand]) begin
          w_grant[o]  = 1'b1;
          w_winner[o] = w_cand;
        end else begin
          w_grant[o]  = w_grant[o];
        end
      end
    end
  end

  // Per-output IDLE/BUSY next state; a grant is taken only from IDLE, release only from BUSY.
  always_comb begin
    w_take    = '0;
    w_release = '0;
    for (int o = 0; o < OUTPUTS; o++) begin
      w_state_nxt[o] = r_state[o];
      case (r_state[o])
        ST_IDLE: begin
          w_take[o]      = w_grant[o];
          w_state_nxt[o] = w_grant[o] ? ST_BUSY : ST_IDLE;
        end
        ST_BUSY: begin
          w_release[o]   = bus.valid_in[r_route_sel[o][IDX_W-1:0]] &
                           bus.ready_in[r_route_sel[o][IDX_W-1:0]] &
                           bus.tail_in[r_route_sel[o][IDX_W-1:0]];
          w_state_nxt[o] = w_release[o] ? ST_IDLE : ST_BUSY;
        end
        default: begin
          w_state_nxt[o] = ST_IDLE;
        end
      endcase
    end
  end

  // An input requests one output only, so a set and a clear never hit the same bit.
  always_comb begin
    w_reserved_nxt = r_reserved;
    for (int o = 0; o < OUTPUTS; o++) begin
      if (w_take[o]) begin
        w_reserved_nxt[w_winner[o]] = 1'b1;
      end else if (w_release[o]) begin
        w_reserved_nxt[r_route_sel[o][IDX_W-1:0]] = 1'b0;
      end else begin
        w_reserved_nxt = w_reserved_nxt;
      end
    end
  end

  // State, path, pointer and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < OUTPUTS; o++) begin
        r_state[o] <= ST_IDLE;
      end
      r_route_sel <= '0;
      r_rr_ptr    <= '0;
      r_reserved  <= '0;
      r_err       <= 1'b0;
    end else begin
      for (int o = 0; o < OUTPUTS; o++) begin
        r_state[o] <= w_state_nxt[o];
        if (w_take[o]) begin
          r_route_sel[o] <= REQUEST_WIDTH'(w_winner[o]);
          r_rr_ptr[o]    <= IDX_W'((int'(w_winner[o]) + 1) % INPUTS);
        end
      end
      r_reserved <= w_reserved_nxt;
      r_err      <= r_err | w_bad;
    end
  end

  // Stale routeSelect after release is intentional; outputBusy qualifies it.
  always_comb begin
    for (int o = 0; o < OUTPUTS; o++) begin
      bus.outputBusy[o] = (r_state[o] == ST_BUSY);
    end
  end

  assign bus.routeSelect  = r_route_sel;
  assign bus.PortReserved = r_reserved;
  assign bus.err_bad_dest = r_err;

endmodule
